svc_uart_tx: RTL
================

Name: svc_uart_tx

Overview:
- 8N1 UART transmitter with a valid/ready byte interface.
- Drives the UART_TX pin for the RISC-V test SoC. It is the serializer stage the rv_lib_test UART MMIO peripheral feeds.
- A one-entry holding buffer lets the CPU queue the next byte while the current frame shifts out, so back-to-back frames have no idle gap.

Parameters:
- CLOCK_FREQ, 100_000_000, clk frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits/s.
- CLKS_PER_BIT (localparam) = CLOCK_FREQ / BAUD_RATE, truncating integer division. Elaboration error if < 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- utx_valid  input  1  byte offered on utx_data.
- utx_data  input  8  byte to transmit; sent LSB first.
- utx_ready  output  1  block can accept a byte this cycle.
- txd  output  1  serial line, idle high; registered.
- busy  output  1  frame in flight or byte buffered.

Behaviour:
- Reset:
  - While rst is high on a clock edge: txd=1, state=IDLE, holding buffer empty, bit/clock counters=0.
  - utx_ready=1 and busy=0 from the cycle after reset.
  - utx_valid is ignored during any cycle rst is high.
- Handshake:
  - Transfer occurs on a cycle with utx_valid && utx_ready.
  - utx_ready = !buf_full, combinational from registered state only; it never depends on utx_valid.
  - utx_data is captured at the handshake edge. Later changes have no effect.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - A handshake loads the shifter directly and moves to START.
  - If buf_full, the buffer moves into the shifter, buf_full is cleared, and the FSM moves to START.
- START: txd=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - txd = shifter[bit_idx] for CLKS_PER_BIT cycles per bit, bits 0..7.
  - After bit 7, go to STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles. At the last stop cycle:
  - if buf_full: move the buffer to the shifter and go to START, so the next start bit follows directly with no idle cycles;
  - else: go to IDLE.
- Handshake outside IDLE: the byte goes to the holding buffer and buf_full is set.
- Latency: txd falls on the first rising edge after the handshake cycle (1 cycle, accepted in IDLE).
- Frame length: exactly 10*CLKS_PER_BIT cycles, from txd falling to the end of the stop bit.
- Counters:
  - Clock counter width = $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and resets on every state/bit transition.
  - Bit index is 3 bits. No wrap beyond 7 is ever used.
- busy = (state != IDLE) || buf_full, combinational from registers.
- Boundary cases:
  - Buffer full: utx_ready=0 until the buffer drains into the shifter. utx_ready rises the cycle after that move.
  - Same cycle as the stop-to-start transfer: no new byte is accepted, because the buffer was full.
  - Reset mid-frame: txd=1 on the next edge; the shifter and buffer contents are discarded; no partial frame resumes.
  - utx_valid held high continuously: a stream of contiguous frames with no gap.
- Glitch-free: txd is a flop output, changing only at bit-period boundaries.

Test Plan (bench: CLOCK_FREQ=100, BAUD_RATE=10, so CLKS_PER_BIT=10):
- Reset → txd=1, utx_ready=1, busy=0. Hold rst 5 cycles with utx_valid=1, utx_data=0xFF → txd stays 1 throughout and after.
- Single byte 0xA5 accepted in IDLE at cycle N → txd=0 cycles N+1..N+10, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, stop high 10 cycles. busy falls at N+101. The bench UART sampler decodes 0xA5.
- Back-to-back 0x55 then 0x0F, utx_valid held:
  - second byte accepted during the first frame's START, after which utx_ready=0 until the buffer drains;
  - second start bit begins exactly 100 cycles after the first;
  - decoded 0x55, 0x0F.
- Stream of 4 bytes (0x00, 0xFF, 0x81, 0x7E) with continuous valid → 400 contiguous cycles, no idle high gaps between frames, all 4 bytes decoded correctly.
- Reset asserted at cycle 35 of a 0x00 frame → txd=1 on the next edge, busy=0, buffer empty. A fresh 0x3C sent afterwards decodes correctly with no residue.
- utx_data changed to 0x00 one cycle after the handshake of 0xC3 → 0xC3 is transmitted.

Source files
------------

// File: rtl/svc_uart_tx.sv
// svc_uart_tx: 8N1 UART transmitter with a valid/ready byte interface and a
// one-entry holding buffer so back-to-back frames leave no idle gap.
module svc_uart_tx #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       utx_valid,
    input  logic [7:0] utx_data,
    output logic       utx_ready,
    output logic       txd,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("svc_uart_tx: CLOCK_FREQ/BAUD_RATE must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shifter;
    logic [7:0]       buf_data;
    logic             buf_full;
    logic             handshake;
    logic             bit_done;

    assign utx_ready = !buf_full;
    assign busy      = (state != IDLE) || buf_full;
    assign handshake = utx_valid && utx_ready;
    assign bit_done  = (clk_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            shifter  <= '0;
            buf_data <= '0;
            buf_full <= 1'b0;
        end else begin
            // Outside IDLE an accepted byte always parks in the holding buffer.
            if (handshake && (state != IDLE)) begin
                buf_data <= utx_data;
                buf_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (handshake) begin
                        shifter <= utx_data;
                        txd     <= 1'b0;
                        state   <= START;
                    end else if (buf_full) begin
                        shifter  <= buf_data;
                        buf_full <= 1'b0;
                        txd      <= 1'b0;
                        state    <= START;
                    end
                end

                START: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        txd     <= shifter[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shifter[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        // A buffered byte chains straight into the next start bit.
                        if (buf_full) begin
                            shifter  <= buf_data;
                            buf_full <= 1'b0;
                            txd      <= 1'b0;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule
